// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 controller and its datapath.
package sha1_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROUND  = 2'd1,
      S_UPDATE = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   localparam int ROUNDS_DEFAULT = 80;

   // Chaining-value IV
   localparam logic [31:0] H0_IV = 32'h67452301;
   localparam logic [31:0] H1_IV = 32'hEFCDAB89;
   localparam logic [31:0] H2_IV = 32'h98BADCFE;
   localparam logic [31:0] H3_IV = 32'h10325476;
   localparam logic [31:0] H4_IV = 32'hC3D2E1F0;

   // Round constants
   localparam logic [31:0] K0 = 32'h5A827999;
   localparam logic [31:0] K1 = 32'h6ED9EBA1;
   localparam logic [31:0] K2 = 32'h8F1BBCDC;
   localparam logic [31:0] K3 = 32'hCA62C1D6;

   // Round-function selects
   localparam logic [1:0] FSEL_CH   = 2'd0;
   localparam logic [1:0] FSEL_PAR1 = 2'd1;
   localparam logic [1:0] FSEL_MAJ  = 2'd2;
   localparam logic [1:0] FSEL_PAR3 = 2'd3;

endpackage

// File: rtl/sha1_ctrl_if.sv
// Block-input and digest-output handshakes between front end and controller.
interface sha1_ctrl_if;
   logic blk_valid;
   logic blk_first;
   logic blk_last;
   logic blk_ready;
   logic digest_valid;
   logic digest_ready;

   modport master (
      output blk_valid, blk_first, blk_last, digest_ready,
      input  blk_ready, digest_valid
   );

   modport slave (
      input  blk_valid, blk_first, blk_last, digest_ready,
      output blk_ready, digest_valid
   );
endinterface

// File: rtl/sha1_round_cnt.sv
// Round index counter: drives t to the schedule and decodes round_idx/f_sel.
module sha1_round_cnt
   import sha1_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_inc,
   input  logic       i_en,
   output logic [7:0] o_t,
   output logic [6:0] o_round_idx,
   output logic [1:0] o_f_sel,
   output logic       o_last
);

   logic [7:0] r_t;
   logic [7:0] w_idx;

   // t advances from the accept edge through UPDATE, then returns to 0
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_t <= '0;
      else if (i_inc)   r_t <= r_t + 8'd1;
   end

   assign w_idx       = r_t - 8'd1;
   assign o_t         = r_t;
   assign o_round_idx = i_en ? w_idx[6:0] : '0;
   assign o_last      = (r_t == 8'(ROUNDS));

   // divide-by-20 via threshold compares; forced to 0 outside rounds
   always_comb begin
      o_f_sel = FSEL_CH;
      if (i_en) begin
         if      (w_idx < 8'd20) o_f_sel = FSEL_CH;
         else if (w_idx < 8'd40) o_f_sel = FSEL_PAR1;
         else if (w_idx < 8'd60) o_f_sel = FSEL_MAJ;
         else                    o_f_sel = FSEL_PAR3;
      end
   end

endmodule

// File: rtl/sha1_ctrl.sv
// SHA-1 sequencing controller: block handshake, round sequencing, H strobes.
module sha1_ctrl
   import sha1_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEFAULT,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   sha1_ctrl_if.slave       bus,
   output logic [7:0]       t,
   output logic             valid_w,
   output logic             load_abcde,
   output logic             init_h,
   output logic             round_en,
   output logic [6:0]       round_idx,
   output logic [1:0]       f_sel,
   output logic             update_h,
   output logic [CNT_W-1:0] blk_cnt,
   output logic             busy
);

   state_e           r_state, w_next;
   logic             r_last;
   logic             r_open;
   logic [CNT_W-1:0] r_blk_cnt;
   logic             w_accept, w_inc, w_clr, w_last_rnd, w_close;

   sha1_round_cnt #(.ROUNDS(ROUNDS)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_clr),
      .i_inc       (w_inc),
      .i_en        (round_en),
      .o_t         (t),
      .o_round_idx (round_idx),
      .o_f_sel     (f_sel),
      .o_last      (w_last_rnd)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next state and per-state strobes
   always_comb begin
      w_next           = r_state;
      bus.blk_ready    = 1'b0;
      bus.digest_valid = 1'b0;
      valid_w          = 1'b0;
      load_abcde       = 1'b0;
      init_h           = 1'b0;
      round_en         = 1'b0;
      update_h         = 1'b0;
      w_accept         = 1'b0;
      w_inc            = 1'b0;
      w_clr            = 1'b0;
      w_close          = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.blk_ready = 1'b1;
            valid_w       = bus.blk_valid;
            load_abcde    = bus.blk_valid;
            if (bus.blk_valid) begin
               w_accept = 1'b1;
               w_inc    = 1'b1;
               // a fresh or restarted message starts from the IV
               init_h   = bus.blk_first | ~r_open;
               w_next   = S_ROUND;
            end
         end
         S_ROUND: begin
            round_en = 1'b1;
            w_inc    = 1'b1;
            if (w_last_rnd) w_next = S_UPDATE;
         end
         S_UPDATE: begin
            update_h = 1'b1;
            w_clr    = 1'b1;
            w_next   = r_last ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            bus.digest_valid = 1'b1;
            if (bus.digest_ready) begin
               w_close = 1'b1;
               w_next  = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // message bookkeeping: last flag, open flag, saturating block count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last    <= 1'b0;
         r_open    <= 1'b0;
         r_blk_cnt <= '0;
      end else if (w_accept) begin
         r_last <= bus.blk_last;
         r_open <= 1'b1;
         if (init_h)           r_blk_cnt <= CNT_W'(1);
         else if (!(&r_blk_cnt)) r_blk_cnt <= r_blk_cnt + CNT_W'(1);
      end else if (w_close) begin
         r_open    <= 1'b0;
         r_blk_cnt <= '0;
      end
   end

   assign blk_cnt = r_blk_cnt;
   assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_sha1_ctrl.sv
// Bench for sha1_ctrl: strobe-trace vector table plus digest sequences
// driven through a behavioural SHA-1 schedule/round datapath.
module tb_sha1_ctrl;
   import sha1_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  t;
   logic        valid_w, load_abcde, init_h, round_en, update_h, busy;
   logic [6:0]  round_idx;
   logic [1:0]  f_sel;
   logic [15:0] blk_cnt;
   logic [511:0] din = '0;

   sha1_ctrl_if u_if ();

   sha1_ctrl #(.ROUNDS(80), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (u_if),
      .t          (t),
      .valid_w    (valid_w),
      .load_abcde (load_abcde),
      .init_h     (init_h),
      .round_en   (round_en),
      .round_idx  (round_idx),
      .f_sel      (f_sel),
      .update_h   (update_h),
      .blk_cnt    (blk_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural datapath ----------------
   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] w_at(input logic [511:0] blk, input int k);
      logic [31:0] w [80];
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i <= k; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
      return w[k];
   endfunction

   function automatic logic [31:0] rnd(input logic [31:0] a, b, c, d, e, w,
                                       input logic [1:0] fs);
      logic [31:0] f, k;
      case (fs)
         2'd0:    begin f = (b & c) | (~b & d);          k = K0; end
         2'd1:    begin f = b ^ c ^ d;                   k = K1; end
         2'd2:    begin f = (b & c) | (b & d) | (c & d); k = K2; end
         default: begin f = b ^ c ^ d;                   k = K3; end
      endcase
      return rol(a, 5) + f + e + k + w;
   endfunction

   logic [511:0] wblk = '0;
   logic [31:0]  hh [5];
   logic [31:0]  va, vb, vc, vd, ve;

   always @(posedge clk) begin
      if (valid_w) wblk <= din;
      if (init_h) begin
         hh[0] <= H0_IV; hh[1] <= H1_IV; hh[2] <= H2_IV; hh[3] <= H3_IV; hh[4] <= H4_IV;
      end else if (update_h) begin
         hh[0] <= hh[0] + va; hh[1] <= hh[1] + vb; hh[2] <= hh[2] + vc;
         hh[3] <= hh[3] + vd; hh[4] <= hh[4] + ve;
      end
      if (load_abcde) begin
         va <= init_h ? H0_IV : hh[0];
         vb <= init_h ? H1_IV : hh[1];
         vc <= init_h ? H2_IV : hh[2];
         vd <= init_h ? H3_IV : hh[3];
         ve <= init_h ? H4_IV : hh[4];
      end else if (round_en) begin
         va <= rnd(va, vb, vc, vd, ve, w_at(wblk, int'(round_idx)), f_sel);
         vb <= va;
         vc <= rol(vb, 30);
         vd <= vc;
         ve <= vd;
      end
   end

   // free-running strobe totals (values of the cycle that just ended)
   int tot_init = 0, tot_ren = 0, tot_upd = 0;
   always @(posedge clk) begin
      tot_init <= tot_init + int'(init_h);
      tot_ren  <= tot_ren  + int'(round_en);
      tot_upd  <= tot_upd  + int'(update_h);
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_fail = 0;
   int s_init, s_ren, s_upd;
   logic acc_init;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // begins just after a posedge; returns just after the accept edge
   task automatic accept(input logic [511:0] d, input logic f, input logic l);
      @(posedge clk); #1;
      din = d;
      u_if.blk_valid = 1'b1; u_if.blk_first = f; u_if.blk_last = l;
      @(negedge clk);
      chk("accept.blk_ready", 32'(u_if.blk_ready), 32'd1);
      acc_init = init_h;
      s_init = tot_init; s_ren = tot_ren; s_upd = tot_upd;
      @(posedge clk); #1;
      u_if.blk_valid = 1'b0; u_if.blk_first = 1'b0; u_if.blk_last = 1'b0;
   endtask

   // cycles after accept until DONE or IDLE; returns at that negedge
   task automatic wait_end(output int lat);
      lat = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (u_if.digest_valid || u_if.blk_ready) return;
         @(posedge clk); #1;
         lat++;
      end
      chk("wait_end.timeout", 32'd1, 32'd0);
   endtask

   task automatic release_digest();
      u_if.digest_ready = 1'b1;
      @(posedge clk); #1;
      u_if.digest_ready = 1'b0;
      @(negedge clk);
      chk("release.busy", 32'(busy), 32'd0);
      chk("release.blk_cnt", 32'(blk_cnt), 32'd0);
      chk("release.digest_valid", 32'(u_if.digest_valid), 32'd0);
   endtask

   task automatic chk_digest(input string nm, input logic [159:0] exp);
      chk({nm, ".h0"}, hh[0], exp[159:128]);
      chk({nm, ".h1"}, hh[1], exp[127:96]);
      chk({nm, ".h2"}, hh[2], exp[95:64]);
      chk({nm, ".h3"}, hh[3], exp[63:32]);
      chk({nm, ".h4"}, hh[4], exp[31:0]);
   endtask

   typedef struct {
      int          adv;
      logic        rst, v, f, l, dr;
      logic        rdy;
      logic [7:0]  t;
      logic        vw, ld, ini, ren;
      logic [6:0]  ridx;
      logic [1:0]  fsel;
      logic        upd, dv, bsy;
      logic [15:0] cnt;
   } vec_t;

   localparam int NV = 26;
   vec_t vt [NV];

   localparam logic [511:0]  BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0]  BLK_M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0]  BLK_M2  = {{15{32'h0}}, 32'h000001c0};
   localparam logic [159:0] DG_ABC  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] DG_M    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [31:0] h0_hold;
      u_if.blk_valid = 0; u_if.blk_first = 0; u_if.blk_last = 0; u_if.digest_ready = 0;

      //        adv rst v f l dr | rdy t  vw ld in ren ridx fs up dv bsy cnt
      vt[0]  = '{1, 1,0,0,0,0,  1, 0, 0,0,0,0,  0, 0, 0,0,0, 0};
      vt[1]  = '{1, 0,0,0,0,0,  1, 0, 0,0,0,0,  0, 0, 0,0,0, 0};
      vt[2]  = '{1, 0,1,1,1,0,  1, 0, 1,1,1,0,  0, 0, 0,0,0, 0};
      vt[3]  = '{1, 0,0,0,0,1,  0, 1, 0,0,0,1,  0, 0, 0,0,1, 1};
      vt[4]  = '{19,0,0,0,0,0,  0,20, 0,0,0,1, 19, 0, 0,0,1, 1};
      vt[5]  = '{1, 0,0,0,0,0,  0,21, 0,0,0,1, 20, 1, 0,0,1, 1};
      vt[6]  = '{19,0,1,1,0,0,  0,40, 0,0,0,1, 39, 1, 0,0,1, 1};
      vt[7]  = '{1, 0,0,0,0,0,  0,41, 0,0,0,1, 40, 2, 0,0,1, 1};
      vt[8]  = '{19,0,0,0,0,0,  0,60, 0,0,0,1, 59, 2, 0,0,1, 1};
      vt[9]  = '{1, 0,0,0,0,0,  0,61, 0,0,0,1, 60, 3, 0,0,1, 1};
      vt[10] = '{19,0,0,0,0,0,  0,80, 0,0,0,1, 79, 3, 0,0,1, 1};
      vt[11] = '{1, 0,0,0,0,0,  0,81, 0,0,0,0,  0, 0, 1,0,1, 1};
      vt[12] = '{1, 0,0,0,0,0,  0, 0, 0,0,0,0,  0, 0, 0,1,1, 1};
      vt[13] = '{1, 0,0,0,0,1,  0, 0, 0,0,0,0,  0, 0, 0,1,1, 1};
      vt[14] = '{1, 0,0,0,0,0,  1, 0, 0,0,0,0,  0, 0, 0,0,0, 0};
      vt[15] = '{1, 0,1,1,0,0,  1, 0, 1,1,1,0,  0, 0, 0,0,0, 0};
      vt[16] = '{1, 0,0,0,0,0,  0, 1, 0,0,0,1,  0, 0, 0,0,1, 1};
      vt[17] = '{81,0,0,0,0,0,  1, 0, 0,0,0,0,  0, 0, 0,0,0, 1};
      vt[18] = '{1, 0,1,0,1,0,  1, 0, 1,1,0,0,  0, 0, 0,0,0, 1};
      vt[19] = '{1, 0,0,0,0,0,  0, 1, 0,0,0,1,  0, 0, 0,0,1, 2};
      vt[20] = '{80,0,0,0,0,0,  0,81, 0,0,0,0,  0, 0, 1,0,1, 2};
      vt[21] = '{1, 0,0,0,0,0,  0, 0, 0,0,0,0,  0, 0, 0,1,1, 2};
      vt[22] = '{1, 0,0,0,0,1,  0, 0, 0,0,0,0,  0, 0, 0,1,1, 2};
      vt[23] = '{1, 0,0,0,0,0,  1, 0, 0,0,0,0,  0, 0, 0,0,0, 0};
      vt[24] = '{1, 0,1,0,1,0,  1, 0, 1,1,1,0,  0, 0, 0,0,0, 0};
      vt[25] = '{1, 0,0,0,0,0,  0, 1, 0,0,0,1,  0, 0, 0,0,1, 1};

      for (int i = 0; i < NV; i++) begin
         repeat (vt[i].adv) @(posedge clk);
         #1;
         rst = vt[i].rst;
         u_if.blk_valid = vt[i].v; u_if.blk_first = vt[i].f;
         u_if.blk_last = vt[i].l; u_if.digest_ready = vt[i].dr;
         @(negedge clk);
         chk($sformatf("v%0d.blk_ready", i),    32'(u_if.blk_ready),    32'(vt[i].rdy));
         chk($sformatf("v%0d.t", i),            32'(t),                 32'(vt[i].t));
         chk($sformatf("v%0d.valid_w", i),      32'(valid_w),           32'(vt[i].vw));
         chk($sformatf("v%0d.load_abcde", i),   32'(load_abcde),        32'(vt[i].ld));
         chk($sformatf("v%0d.init_h", i),       32'(init_h),            32'(vt[i].ini));
         chk($sformatf("v%0d.round_en", i),     32'(round_en),          32'(vt[i].ren));
         chk($sformatf("v%0d.round_idx", i),    32'(round_idx),         32'(vt[i].ridx));
         chk($sformatf("v%0d.f_sel", i),        32'(f_sel),             32'(vt[i].fsel));
         chk($sformatf("v%0d.update_h", i),     32'(update_h),          32'(vt[i].upd));
         chk($sformatf("v%0d.digest_valid", i), 32'(u_if.digest_valid), 32'(vt[i].dv));
         chk($sformatf("v%0d.busy", i),         32'(busy),              32'(vt[i].bsy));
         chk($sformatf("v%0d.blk_cnt", i),      32'(blk_cnt),           32'(vt[i].cnt));
      end
      // drain the single-block message opened by the last vectors
      u_if.digest_ready = 1'b1;
      begin : drain
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) disable drain;
         end
         chk("drain.timeout", 32'd1, 32'd0);
      end
      u_if.digest_ready = 1'b0;

      // single block "abc", strobe counts, then backpressure
      accept(BLK_ABC, 1'b1, 1'b1);
      wait_end(lat);
      chk("abc.latency", 32'(lat), 32'd82);
      chk("abc.digest_valid", 32'(u_if.digest_valid), 32'd1);
      chk_digest("abc", DG_ABC);
      chk("abc.blk_cnt", 32'(blk_cnt), 32'd1);
      chk("abc.init_pulses", 32'(tot_init - s_init), 32'd1);
      chk("abc.round_cycles", 32'(tot_ren - s_ren), 32'd80);
      chk("abc.update_pulses", 32'(tot_upd - s_upd), 32'd1);
      h0_hold = hh[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp.digest_valid", 32'(u_if.digest_valid), 32'd1);
         chk("bp.blk_ready", 32'(u_if.blk_ready), 32'd0);
         chk("bp.h0", hh[0], h0_hold);
      end
      chk_digest("bp", DG_ABC);
      release_digest();

      // two-block message
      accept(BLK_M1, 1'b1, 1'b0);
      wait_end(lat);
      chk("m1.ready_latency", 32'(lat), 32'd82);
      chk("m1.blk_ready", 32'(u_if.blk_ready), 32'd1);
      chk("m1.digest_valid", 32'(u_if.digest_valid), 32'd0);
      accept(BLK_M2, 1'b0, 1'b1);
      chk("m2.init_h", 32'(acc_init), 32'd0);
      wait_end(lat);
      chk("m2.latency", 32'(lat), 32'd82);
      chk_digest("m2", DG_M);
      chk("m2.blk_cnt", 32'(blk_cnt), 32'd2);
      release_digest();

      // reset mid-round abandons the block without an H update
      accept(BLK_ABC, 1'b1, 1'b1);
      begin : find40
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (t == 8'd40) disable find40;
         end
         chk("rst.find_t40", 32'd1, 32'd0);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst.t", 32'(t), 32'd0);
      chk("rst.round_en", 32'(round_en), 32'd0);
      chk("rst.update_h", 32'(update_h), 32'd0);
      chk("rst.valid_w", 32'(valid_w), 32'd0);
      chk("rst.digest_valid", 32'(u_if.digest_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.blk_cnt", 32'(blk_cnt), 32'd0);
      chk("rst.no_update", 32'(tot_upd - s_upd), 32'd0);
      accept(BLK_ABC, 1'b1, 1'b1);
      wait_end(lat);
      chk_digest("post_rst", DG_ABC);
      release_digest();

      // restart: blk_first while a message is open
      accept(BLK_M1, 1'b1, 1'b0);
      wait_end(lat);
      chk("rs.open_cnt", 32'(blk_cnt), 32'd1);
      accept(BLK_ABC, 1'b1, 1'b1);
      chk("rs.init_h", 32'(acc_init), 32'd1);
      @(negedge clk);
      chk("rs.blk_cnt", 32'(blk_cnt), 32'd1);
      wait_end(lat);
      chk_digest("rs", DG_ABC);
      chk("rs.final_cnt", 32'(blk_cnt), 32'd1);
      release_digest();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sha1_ctrl.md
Name: sha1_ctrl

Overview:
- Sequencing controller for the SHA-1 datapath.
- Accepts 512-bit message blocks over a valid/ready handshake and drives the round index `t` and `valid_w` into the `sha1_w` message-schedule generator.
- Issues per-round enables and function selects to the compression round logic, and pulses chaining-value init/update strobes.
- Presents a digest-ready handshake after the last block of a message.
- Sits between the padding/framing front end and the `sha1_w` + round datapath.

Parameters:
- ROUNDS, 80, number of compression rounds per block; fixed for SHA-1, parameterised only for test shortening.
- CNT_W, 16, width of the per-message block counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- blk_valid  in  1  a 512-bit block (wired externally to the schedule `din`) is available
- blk_first  in  1  qualifies blk_valid: first block of a message
- blk_last  in  1  qualifies blk_valid: last block of a message
- blk_ready  out  1  controller accepts a block this cycle
- t  out  8  round index to schedule generator
- valid_w  out  1  schedule load strobe
- load_abcde  out  1  copy H0..H4 into working registers a..e
- init_h  out  1  load H0..H4 with the SHA-1 IV
- round_en  out  1  execute one compression round
- round_idx  out  7  current round 0..79
- f_sel  out  2  0: Ch/K0 (rounds 0-19), 1: Parity/K1 (20-39), 2: Maj/K2 (40-59), 3: Parity/K3 (60-79)
- update_h  out  1  H_i += working var
- digest_valid  out  1  H0..H4 hold a final digest
- digest_ready  in  1  consumer takes the digest
- blk_cnt  out  CNT_W  blocks accepted in current message, saturating
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, t = 0, blk_cnt = 0.
  - All strobes (valid_w, load_abcde, init_h, round_en, update_h, digest_valid) = 0.
  - round_idx = 0, f_sel = 0.
  - Reset mid-block or in DONE abandons the message; no update_h is issued.
- FSM states: IDLE, ROUND, UPDATE, DONE.
- IDLE:
  - blk_ready = 1, t = 0, valid_w = blk_valid (combinational), load_abcde = blk_valid.
  - Accept happens when blk_valid = 1. On accept the schedule captures `din` at this edge.
  - If blk_first, or if no message is open: init_h = 1 in the same cycle. The datapath gives init_h priority, so a..e load from the IV. blk_cnt := 1.
  - Otherwise blk_cnt := blk_cnt + 1, saturating at all-ones.
  - The blk_last value is latched.
  - Next state: ROUND.
  - With no valid, t stays 0 and valid_w = 0, so the schedule clears itself.
- ROUND:
  - t counts 1..ROUNDS, one per cycle. Schedule `w` at t = k is W[k-1].
  - round_en = 1, round_idx = t-1, f_sel = (t-1)/20.
  - blk_ready = 0.
  - After t = ROUNDS: next state UPDATE.
- UPDATE (1 cycle):
  - t = ROUNDS+1, which is outside the schedule's active range and clears it.
  - update_h = 1, round_en = 0.
  - Next state: DONE if latched last, else IDLE with the message left open.
- DONE:
  - t = 0, digest_valid = 1, held until digest_ready.
  - On digest_ready: close the message, blk_cnt := 0, next state IDLE.
  - blk_ready = 0 in DONE; no overlap with the next message.
- Timing:
  - Accept at cycle 0.
  - Rounds on cycles 1..80.
  - update_h on cycle 81.
  - digest_valid from cycle 82, or blk_ready again at cycle 82 for non-last blocks.
  - Throughput is 82 cycles per block.
- Boundary cases:
  - blk_first with an open message: restart (init_h = 1, blk_cnt := 1); the prior partial message is discarded.
  - blk_first and blk_last together: single-block message.
  - digest_ready while not DONE: ignored.
  - Input control signals are ignored outside IDLE.
- round_idx and f_sel are 0 whenever round_en = 0.

Decomposition:
- Package `sha1_pkg` holds:
  - state enum
  - IV constants H0..H4 (67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0)
  - K0..K3 (5A827999, 6ED9EBA1, 8F1BBCDC, CA62C1D6)
  - f_sel encodings
  - ROUNDS_DEFAULT = 80
- One natural sub-module, `sha1_round_cnt`:
  - t/round_idx counter plus f_sel decode (divide-by-20 via compare against 20/40/60).
  - FSM and handshake stay in `sha1_ctrl`.

Test Plan:
- Single block "abc" (padded, first = last = 1) with real `sha1_w` + round datapath:
  - digest_valid at cycle 82 after accept.
  - H = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
  - blk_cnt = 1.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - blk_ready reasserts at cycle 82 after the first accept.
  - Final H = 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - blk_cnt = 2.
- Strobe trace:
  - Check t = 0, 1..80, 81, 0.
  - round_en high for exactly 80 cycles.
  - f_sel transitions at round_idx 20/40/60.
  - update_h and init_h are each a single-cycle pulse.
- Backpressure:
  - Hold digest_ready = 0 for 10 cycles: digest_valid is stable, blk_ready = 0, H unchanged.
  - Then digest_ready = 1: IDLE next cycle, blk_cnt = 0.
- Reset mid-round:
  - Assert rst at t = 40: next cycle t = 0, all strobes 0, busy = 0.
  - A following "abc" block still yields a9993e36….
- Restart:
  - blk_first = 1 while a message is open (blk_cnt = 1): init_h pulses and blk_cnt = 1.
  - Digest equals the single-block result.
